// File: rtl/xbar_slave_forward_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | xbar_slave_forward_arbiter_if                                              |
// | AW/W head status and forwarding controls between master-side queues and    |
// | one slave port's arbiter. Revision: 1.0                                    |
// +----------------------------------------------------------------------------+
interface xbar_slave_forward_arbiter_if #(
    parameter int masters = 2,
    parameter int slaves  = 2
);
    localparam int MST_W = (masters > 1) ? $clog2(masters) : 1;
    localparam int DST_W = (slaves  > 1) ? $clog2(slaves)  : 1;

    logic [masters-1:0]            master_write_addr_fifo_empty;
    logic [masters-1:0][DST_W-1:0] write_addr_forward_dest_slave;
    logic [masters-1:0]            master_write_data_fifo_empty;
    logic [masters-1:0][DST_W-1:0] write_data_forward_dest_slave;
    logic [masters-1:0]            WLAST;
    logic                          slave_aw_fifo_full;
    logic                          slave_w_fifo_full;
    logic [masters-1:0]            slave_write_addr_fifo_full;
    logic [masters-1:0]            slave_write_data_fifo_full;
    logic [MST_W-1:0]              grant_aw_master;
    logic [MST_W-1:0]              grant_w_master;
    logic                          aw_push;
    logic                          w_push;
    logic                          order_empty;
    logic                          order_full;

    // Arbiter side
    modport slave (
        input  master_write_addr_fifo_empty, write_addr_forward_dest_slave,
        input  master_write_data_fifo_empty, write_data_forward_dest_slave,
        input  WLAST, slave_aw_fifo_full, slave_w_fifo_full,
        output slave_write_addr_fifo_full, slave_write_data_fifo_full,
        output grant_aw_master, grant_w_master, aw_push, w_push,
        output order_empty, order_full
    );

    // Queue / fabric side
    modport master (
        output master_write_addr_fifo_empty, write_addr_forward_dest_slave,
        output master_write_data_fifo_empty, write_data_forward_dest_slave,
        output WLAST, slave_aw_fifo_full, slave_w_fifo_full,
        input  slave_write_addr_fifo_full, slave_write_data_fifo_full,
        input  grant_aw_master, grant_w_master, aw_push, w_push,
        input  order_empty, order_full
    );
endinterface
`default_nettype wire

// File: rtl/xbar_slave_forward_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | xbar_slave_forward_arbiter                                                 |
// | Round-robin AW grant per slave port; W bursts follow AW grant order via an |
// | order FIFO. XBAR_FWD_ARB_FIXED_PRIORITY_EN selects fixed priority.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module xbar_slave_forward_arbiter #(
    parameter int masters           = 2,
    parameter int slaves            = 2,
    parameter int i_am_slave_number = 0,
    parameter int order_depth       = 8
) (
    input  wire logic ACLK,
    input  wire logic ARESET,
    xbar_slave_forward_arbiter_if.slave bus
);
    localparam int MST_W = (masters > 1) ? $clog2(masters) : 1;
    localparam int DST_W = (slaves  > 1) ? $clog2(slaves)  : 1;
    localparam int PTR_W = $clog2(order_depth);
    localparam logic [DST_W-1:0] SELF  = DST_W'(i_am_slave_number);
    localparam logic [PTR_W:0]   DEPTH = (PTR_W+1)'(order_depth);
    localparam logic [MST_W-1:0] LAST_MASTER = MST_W'(masters - 1);

    logic [masters-1:0] req;
    logic [MST_W-1:0]   grant_aw;
    logic [MST_W-1:0]   dm;
    logic               any_req;
    logic               aw_push;
    logic               w_push;
    logic               pop;
    logic               order_empty;
    logic               order_full;

    logic [MST_W-1:0]   order_mem [order_depth];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;

    always_comb begin
        req = '0;
        for (int m = 0; m < masters; m++) begin
            req[m] = ~bus.master_write_addr_fifo_empty[m] &
                     (bus.write_addr_forward_dest_slave[m] == SELF);
        end
    end

    assign any_req = |req;

`ifdef XBAR_FWD_ARB_FIXED_PRIORITY_EN
    // Descending scan so the lowest requesting index is the last writer.
    always_comb begin
        grant_aw = '0;
        for (int m = masters - 1; m >= 0; m--) begin
            if (req[m]) begin
                grant_aw = MST_W'(m);
            end
        end
    end
`else
    logic [MST_W-1:0] rr_ptr;
    logic             found;

    always_comb begin
        grant_aw = rr_ptr;
        found    = 1'b0;
        for (int i = 0; i < masters; i++) begin
            if (!found && req[(int'(rr_ptr) + i) % masters]) begin
                grant_aw = MST_W'((int'(rr_ptr) + i) % masters);
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rr_ptr <= '0;
        end else if (aw_push) begin
            rr_ptr <= (grant_aw == LAST_MASTER) ? '0 : grant_aw + 1'b1;
        end
    end
`endif

    assign order_empty = (count == '0);
    assign order_full  = (count == DEPTH);

    // Reset gates the grant path so a live request cannot leak through.
    assign aw_push = ~ARESET & any_req & ~bus.slave_aw_fifo_full & ~order_full;

    // Empty FIFO reads a defined zero rather than stale storage.
    assign dm = order_empty ? '0 : order_mem[rd_ptr];

    assign w_push = ~order_empty & ~bus.master_write_data_fifo_empty[dm] &
                    (bus.write_data_forward_dest_slave[dm] == SELF) &
                    ~bus.slave_w_fifo_full;
    assign pop    = w_push & bus.WLAST[dm];

    always_comb begin
        bus.slave_write_addr_fifo_full = '1;
        bus.slave_write_data_fifo_full = '1;
        for (int m = 0; m < masters; m++) begin
            bus.slave_write_addr_fifo_full[m] = ~(aw_push && (grant_aw == MST_W'(m)));
            bus.slave_write_data_fifo_full[m] = ~(w_push  && (dm       == MST_W'(m)));
        end
    end

    assign bus.grant_aw_master = ARESET ? '0 : grant_aw;
    assign bus.grant_w_master  = dm;
    assign bus.aw_push         = aw_push;
    assign bus.w_push          = w_push;
    assign bus.order_empty     = order_empty;
    assign bus.order_full      = order_full;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (aw_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({aw_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (aw_push) begin
            order_mem[wr_ptr] <= grant_aw;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_xbar_slave_forward_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_xbar_slave_forward_arbiter                                              |
// | Directed bench for the per-slave forwarding arbiter. Revision: 1.0         |
// +----------------------------------------------------------------------------+
module tb_xbar_slave_forward_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    xbar_slave_forward_arbiter_if #(.masters(2), .slaves(2)) bus ();

    xbar_slave_forward_arbiter #(
        .masters(2), .slaves(2), .i_am_slave_number(0), .order_depth(8)
    ) dut (
        .ACLK   (clk),
        .ARESET (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.master_write_addr_fifo_empty  = 2'b11;
        bus.write_addr_forward_dest_slave = '0;
        bus.master_write_data_fifo_empty  = 2'b11;
        bus.write_data_forward_dest_slave = '0;
        bus.WLAST                         = 2'b00;
        bus.slave_aw_fifo_full            = 1'b0;
        bus.slave_w_fifo_full             = 1'b0;
    endtask

    // Expected grants while both masters request continuously
`ifdef XBAR_FWD_ARB_FIXED_PRIORITY_EN
    logic [2:0] rr_exp = 3'b000;
`else
    logic [2:0] rr_exp = 3'b010;
`endif

    initial begin
        idle();
        #1;
        check("reset_aw_push", bus.aw_push, 0);
        check("reset_w_push", bus.w_push, 0);
        check("reset_aw_full", bus.slave_write_addr_fifo_full, 2'b11);
        check("reset_w_full", bus.slave_write_data_fifo_full, 2'b11);
        check("reset_grant_aw", bus.grant_aw_master, 0);
        check("reset_grant_w", bus.grant_w_master, 0);
        check("reset_order_empty", bus.order_empty, 1);
        check("reset_order_full", bus.order_full, 0);

        @(negedge clk);
        rst = 1'b0;

        // Destination filter: M0 head targets slave 1
        bus.master_write_addr_fifo_empty = 2'b10;
        bus.write_addr_forward_dest_slave[0] = 1'b1;
        #1;
        check("filter_aw_push", bus.aw_push, 0);
        check("filter_aw_full", bus.slave_write_addr_fifo_full, 2'b11);
        check("filter_grant", bus.grant_aw_master, 0);

        // Fairness: both masters request slave 0 for three cycles
        @(negedge clk);
        bus.write_addr_forward_dest_slave = '0;
        bus.master_write_addr_fifo_empty = 2'b00;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("rr_grant_%0d", i), bus.grant_aw_master, rr_exp[i]);
            check($sformatf("rr_push_%0d", i), bus.aw_push, 1);
            check($sformatf("rr_aw_full_%0d", i), bus.slave_write_addr_fifo_full,
                  rr_exp[i] ? 2'b01 : 2'b10);
            @(negedge clk);
        end

        // Start a burst from the order head, then reset mid-burst (occupancy 3)
        bus.master_write_addr_fifo_empty = 2'b11;
        bus.master_write_data_fifo_empty = 2'b10;
        #1;
        check("pre_rst_w_push", bus.w_push, 1);
        check("pre_rst_grant_w", bus.grant_w_master, 0);
        check("pre_rst_w_full", bus.slave_write_data_fifo_full, 2'b10);
        @(negedge clk);
        bus.master_write_addr_fifo_empty = 2'b00;
        rst = 1'b1;
        #1;
        check("midrst_order_empty", bus.order_empty, 1);
        check("midrst_order_full", bus.order_full, 0);
        check("midrst_aw_push", bus.aw_push, 0);
        check("midrst_w_push", bus.w_push, 0);
        check("midrst_aw_full", bus.slave_write_addr_fifo_full, 2'b11);
        check("midrst_w_full", bus.slave_write_data_fifo_full, 2'b11);
        check("midrst_grant_aw", bus.grant_aw_master, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.master_write_addr_fifo_empty = 2'b11;
        #1;
        check("post_rst_no_resume", bus.w_push, 0);
        check("post_rst_empty", bus.order_empty, 1);

        // Ordering: AW M1 (4 beats) then AW M0 (2 beats); M0 W ready first
        @(negedge clk);
        bus.master_write_addr_fifo_empty = 2'b01;
        #1;
        check("ord_aw1_grant", bus.grant_aw_master, 1);
        check("ord_aw1_push", bus.aw_push, 1);
        check("ord_aw1_no_w", bus.w_push, 0);
        @(negedge clk);
        bus.master_write_addr_fifo_empty = 2'b10;
        #1;
        check("ord_aw0_grant", bus.grant_aw_master, 0);
        check("ord_aw0_push", bus.aw_push, 1);
        check("ord_head_m1", bus.grant_w_master, 1);
        check("ord_m1_not_ready", bus.w_push, 0);
        check("ord_m0_blocked", bus.slave_write_data_fifo_full, 2'b11);
        @(negedge clk);
        bus.master_write_addr_fifo_empty = 2'b11;
        bus.master_write_data_fifo_empty = 2'b00;
        for (int b = 0; b < 4; b++) begin
            bus.WLAST = (b == 3) ? 2'b10 : 2'b00;
            if (b == 2) begin
                bus.slave_w_fifo_full = 1'b1;
                #1;
                check("bp_w_push", bus.w_push, 0);
                check("bp_head", bus.grant_w_master, 1);
                check("bp_w_full", bus.slave_write_data_fifo_full, 2'b11);
                @(negedge clk);
                bus.slave_w_fifo_full = 1'b0;
            end
            #1;
            check($sformatf("ord_m1_beat%0d_push", b), bus.w_push, 1);
            check($sformatf("ord_m1_beat%0d_full", b), bus.slave_write_data_fifo_full, 2'b01);
            @(negedge clk);
        end
        for (int b = 0; b < 2; b++) begin
            bus.WLAST = (b == 1) ? 2'b01 : 2'b00;
            #1;
            check($sformatf("ord_m0_beat%0d_head", b), bus.grant_w_master, 0);
            check($sformatf("ord_m0_beat%0d_full", b), bus.slave_write_data_fifo_full, 2'b10);
            @(negedge clk);
        end
        idle();
        #1;
        check("ord_drained", bus.order_empty, 1);

        // Order FIFO full: eight AWs from M0 with no W data
        @(negedge clk);
        bus.master_write_addr_fifo_empty = 2'b10;
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("fill_push_%0d", i), bus.aw_push, 1);
            @(negedge clk);
        end
        #1;
        check("full_flag", bus.order_full, 1);
        check("full_9th_held", bus.aw_push, 0);
        check("full_aw_full", bus.slave_write_addr_fifo_full, 2'b11);
        @(negedge clk);
        bus.master_write_data_fifo_empty = 2'b10;
        bus.WLAST = 2'b01;
        #1;
        check("full_pop_w_push", bus.w_push, 1);
        check("full_pop_aw_blocked", bus.aw_push, 0);
        @(negedge clk);
        bus.master_write_data_fifo_empty = 2'b11;
        #1;
        check("freed_not_full", bus.order_full, 0);
        check("freed_aw_push", bus.aw_push, 1);
        @(negedge clk);
        #1;
        check("refull_flag", bus.order_full, 1);
        check("refull_held", bus.aw_push, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
